// File: rtl/wb_burst_slave_pkg.sv
// Shared encodings for the Wishbone burst slave: cycle/burst type codes,
// FSM state encoding and the word-address type.
package wb_burst_slave_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ACK   = 2'b10,
        ST_BURST = 2'b11
    } state_e;

    localparam int unsigned WORD_AW = 30;
    typedef logic [WORD_AW-1:0] word_addr_t;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word address of a Wishbone burst: increment, with the low bits
// wrapping for wrap-4/8/16 bursts; linear bursts never wrap.
module wb_burst_addr_gen
    import wb_burst_slave_pkg::*;
(
    input  logic [WORD_AW-1:0] addr_i,
    input  logic [1:0]         bte_i,
    output logic [WORD_AW-1:0] addr_o
);

    logic [WORD_AW-1:0] inc;

    always_comb begin
        inc = addr_i + WORD_AW'(1);
        case (bte_e'(bte_i))
            BTE_WRAP4:  addr_o = {addr_i[WORD_AW-1:2], inc[1:0]};
            BTE_WRAP8:  addr_o = {addr_i[WORD_AW-1:3], inc[2:0]};
            BTE_WRAP16: addr_o = {addr_i[WORD_AW-1:4], inc[3:0]};
            default:    addr_o = inc;
        endcase
    end

endmodule

// File: rtl/wb_burst_slave.sv
// Wishbone B3 memory slave with programmable first-beat wait states and
// zero-wait incrementing/wrapping bursts; out-of-range words terminate with err.
module wb_burst_slave
    import wb_burst_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    word_addr_t  addr_q, addr_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] mem [DEPTH];

    word_addr_t  next_addr;
    word_addr_t  req_addr;
    word_addr_t  load_addr;
    logic        load;
    logic        mem_we;
    logic        req;
    logic        beat_gate;
    logic        unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign req_addr   = wb_adr_i[31:2];
    assign unused_adr = ^wb_adr_i[1:0];

    function automatic logic out_of_range(input word_addr_t a);
        return {2'b00, a} >= DEPTH;
    endfunction

    wb_burst_addr_gen u_addr_gen (
        .addr_i (addr_q),
        .bte_i  (wb_bte_i),
        .addr_o (next_addr)
    );

    // ack_q/err_q are loaded together with dat_q whenever a new beat's word
    // is fetched, so they always describe the beat currently being presented.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        ack_d     = ack_q;
        err_d     = err_q;
        dat_d     = dat_q;
        load_addr = addr_q;
        load      = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                err_d = 1'b0;
                if (req) begin
                    addr_d = req_addr;
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_ACK;
                        load_addr = req_addr;
                        load      = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK, ST_BURST: begin
                if (!wb_cyc_i || (!wb_stb_i && state_q == ST_ACK)) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end else if (wb_stb_i) begin
                    mem_we = wb_we_i & ack_q;
                    if (err_q || wb_cti_i != CTI_INCR) begin
                        state_d = ST_IDLE;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        state_d   = ST_BURST;
                        addr_d    = next_addr;
                        load_addr = next_addr;
                        load      = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            ack_d = !out_of_range(load_addr);
            err_d = out_of_range(load_addr);
            dat_d = mem[load_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[addr_q[IDX_W-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Burst beats terminate only while the master strobes; a stall holds the beat.
    assign beat_gate = (state_q == ST_BURST) ? req : 1'b1;
    assign wb_ack_o  = ack_q & beat_gate;
    assign wb_err_o  = err_q & beat_gate;
    assign wb_dat_o  = dat_q;
    assign wb_rty_o  = 1'b0;

endmodule

// File: tb/tb_wb_burst_slave.sv
// Randomised self-checking bench for wb_burst_slave against a word-array
// reference model with burst address sequences computed arithmetically.
module tb_wb_burst_slave;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned WS    = 2;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    always #5 wb_clk = ~wb_clk;

    wb_burst_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wdat  [16];
    logic        r_ack [16];
    logic        r_err [16];
    logic [31:0] r_dat [16];
    int          r_cyc [16];
    int          r_nb, r_lat, r_stall_viol, r_both;
    logic        r_post;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned beat_word(input int unsigned w0, input int i, input logic [1:0] bte);
        int unsigned n;
        case (bte)
            2'b01:   n = 4;
            2'b10:   n = 8;
            2'b11:   n = 16;
            default: n = 0;
        endcase
        if (n == 0) return w0 + i;
        return (w0 & ~(n - 1)) | ((w0 + i) % n);
    endfunction

    task automatic idle_bus();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
        wb_bte_i = 2'b00; wb_sel_i = 4'h0; wb_adr_i = '0; wb_dat_i = '0;
    endtask

    // One master transaction of nb beats; a stall of stall_len cycles is
    // inserted once stall_after beats have terminated (stall_after < 0: none).
    task automatic bus_xfer(input bit we, input logic [31:0] adr, input int nb, input logic [1:0] bte,
                            input logic [3:0] sel, input int stall_after, input int stall_len);
        int k = 0, cc = 0, stall = 0;
        bit done = 0;
        logic [2:0] cls_cti;
        case ($urandom_range(0, 2))
            0:       cls_cti = 3'b000;
            1:       cls_cti = 3'b111;
            default: cls_cti = 3'b011;
        endcase
        r_lat = -1; r_stall_viol = 0; r_both = 0;
        while (!done && cc < 100) begin
            @(negedge wb_clk);
            cc++;
            wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel; wb_bte_i = bte;
            wb_dat_i = wdat[k];
            wb_cti_i = (nb == 1) ? cls_cti : ((k == nb - 1) ? 3'b111 : 3'b010);
            wb_stb_i = (stall > 0) ? 1'b0 : 1'b1;
            if (stall > 0) stall--;
            #1;
            if (wb_ack_o && wb_err_o) r_both++;
            if (!wb_stb_i) begin
                if (wb_ack_o || wb_err_o) r_stall_viol++;
            end else if (wb_ack_o || wb_err_o) begin
                if (k == 0) r_lat = cc - 1;
                r_ack[k] = wb_ack_o; r_err[k] = wb_err_o; r_dat[k] = wb_dat_o; r_cyc[k] = cc;
                k++;
                if (wb_err_o || k == nb) done = 1;
                if (k == stall_after) stall = stall_len;
            end
        end
        r_nb = k;
        @(negedge wb_clk);
        idle_bus();
        #1;
        r_post = wb_ack_o | wb_err_o;
    endtask

    task automatic txn(input string name, input bit we, input int unsigned word, input int nb,
                       input logic [1:0] bte, input logic [3:0] sel, input int stall_after, input int stall_len);
        int exp_nb = nb;
        int unsigned w;
        bit oor;
        int dly;
        bus_xfer(we, 32'(word) << 2, nb, bte, sel, stall_after, stall_len);
        for (int i = 0; i < nb; i++) begin
            if (beat_word(word, i, bte) >= DEPTH) begin
                exp_nb = i + 1;
                break;
            end
        end
        check($sformatf("%s_nbeats", name), 32'(r_nb), 32'(exp_nb));
        check($sformatf("%s_latency", name), 32'(r_lat), 32'(WS + 1));
        for (int i = 0; i < exp_nb; i++) begin
            w   = beat_word(word, i, bte);
            oor = (w >= DEPTH);
            if (i < r_nb) begin
                check($sformatf("%s_b%0d_ack", name, i), 32'(r_ack[i]), 32'(!oor));
                check($sformatf("%s_b%0d_err", name, i), 32'(r_err[i]), 32'(oor));
                if (i > 0) begin
                    dly = (stall_after >= 0 && i >= stall_after) ? stall_len : 0;
                    check($sformatf("%s_b%0d_cycle", name, i), 32'(r_cyc[i] - r_cyc[0]), 32'(i + dly));
                end
                if (!we && !oor) check($sformatf("%s_b%0d_data", name, i), r_dat[i], ref_mem[w]);
            end
            if (we && !oor) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[w][8*b +: 8] = wdat[i][8*b +: 8];
            end
        end
        check($sformatf("%s_post_idle", name), 32'(r_post), 32'd0);
        check($sformatf("%s_stall_term", name), 32'(r_stall_viol), 32'd0);
        check($sformatf("%s_ack_and_err", name), 32'(r_both), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int got;
        wb_rst_n = 1'b0;
        idle_bus();
        repeat (3) @(negedge wb_clk);
        #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_err_o), 32'd0);
        check("rst_rty", 32'(wb_rty_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // Known contents for words 0..127 via linear write bursts.
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            txn("preload", 1'b1, 32'(b * 16), 16, 2'b00, 4'hF, -1, 0);
        end

        wdat[0] = 32'hDEADBEEF;
        txn("wr_dead", 1'b1, 4, 1, 2'b00, 4'hF, -1, 0);
        txn("rd_dead", 1'b0, 4, 1, 2'b00, 4'hF, -1, 0);
        check("rd_dead_value", r_dat[0], 32'hDEADBEEF);

        wdat[0] = 32'h11223344;
        txn("wr_full", 1'b1, 8, 1, 2'b00, 4'hF, -1, 0);
        wdat[0] = 32'hAABBCCDD;
        txn("wr_sel5", 1'b1, 8, 1, 2'b00, 4'b0101, -1, 0);
        txn("rd_merge", 1'b0, 8, 1, 2'b00, 4'h0, -1, 0);
        check("rd_merge_value", r_dat[0], 32'h11BB33DD);

        txn("wrap4_rd", 1'b0, 2, 4, 2'b01, 4'hF, -1, 0);
        txn("stall_rd", 1'b0, 32, 5, 2'b00, 4'hF, 2, 2);

        wdat[0] = $urandom;
        txn("wr_top", 1'b1, DEPTH - 1, 1, 2'b00, 4'hF, -1, 0);
        txn("oor_rd", 1'b0, DEPTH, 1, 2'b00, 4'hF, -1, 0);
        txn("oor_burst", 1'b0, DEPTH - 1, 4, 2'b00, 4'hF, -1, 0);
        for (int i = 0; i < 4; i++) wdat[i] = $urandom;
        txn("oor_wr_burst", 1'b1, DEPTH - 1, 4, 2'b00, 4'hF, -1, 0);
        txn("after_err_rd", 1'b0, 5, 1, 2'b00, 4'hF, -1, 0);

        // Reset asserted in the middle of a linear read burst.
        @(negedge wb_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'(16 << 2);
        wb_cti_i = 3'b010; wb_bte_i = 2'b00; wb_sel_i = 4'hF;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge wb_clk);
            #1;
            if (wb_ack_o) got++;
        end
        check("rstmid_beats", 32'(got), 32'd2);
        @(negedge wb_clk);
        wb_rst_n = 1'b0;
        #1;
        check("rstmid_ack", 32'(wb_ack_o), 32'd0);
        check("rstmid_err", 32'(wb_err_o), 32'd0);
        check("rstmid_dat", wb_dat_o, 32'd0);
        idle_bus();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        txn("rstmid_rd16", 1'b0, 16, 1, 2'b00, 4'hF, -1, 0);
        txn("rstmid_rd17", 1'b0, 17, 1, 2'b00, 4'hF, -1, 0);

        for (int t = 0; t < 40; t++) begin
            bit we;
            int unsigned word;
            int nb, sa, sl;
            logic [1:0] bte;
            logic [3:0] sel;
            we   = 1'($urandom_range(0, 1));
            word = $urandom_range(0, 63);
            case ($urandom_range(0, 3))
                0:       nb = 1;
                1:       nb = 4;
                2:       nb = $urandom_range(2, 8);
                default: nb = $urandom_range(9, 16);
            endcase
            bte = 2'($urandom);
            sel = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            sa = -1; sl = 0;
            if (nb > 1 && $urandom_range(0, 1) == 1) begin
                sa = $urandom_range(1, nb - 1);
                sl = $urandom_range(1, 3);
            end
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            txn($sformatf("rnd%0d", t), we, word, nb, bte, sel, sa, sl);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
